// File: rtl/chacha_pkg.sv
// Shared definitions for the sequential ChaCha block engine.
//   state_e   : engine FSM states
//   SIGMA     : "expand 32-byte k" constant words, word 0 in the low 32 bits
//   COL_IDX   : column quarter-round word indices, COL_IDX[qr][k]
//   DIAG_IDX  : diagonal quarter-round word indices, DIAG_IDX[qr][k]
//   beats_of  : number of bus beats in a 512-bit block
package chacha_pkg;

  typedef enum logic [2:0] {IDLE, COPY, CALC, SUM, OUT, INC} state_e;

  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32,
                                        32'h3320646e, 32'h61707865};

  // Each 16-bit row holds {k3,k2,k1,k0}; row q is quarter-round q.
  localparam logic [3:0][3:0][3:0] COL_IDX  = 64'hFB73_EA62_D951_C840;
  localparam logic [3:0][3:0][3:0] DIAG_IDX = 64'hE943_D872_CB61_FA50;

  function automatic int beats_of(input int bus_w);
    return 512 / bus_w;
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round.
//   a, b, c, d     : input words
//   qa, qb, qc, qd : quarter-round results
module chacha_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] qc,
  output logic [31:0] qd
);

  logic [31:0] a1, b1, c1, d1, t_d1, t_b1, t_d2, t_b2;

  assign a1   = a + b;
  assign t_d1 = d ^ a1;
  assign d1   = {t_d1[15:0], t_d1[31:16]};
  assign c1   = c + d1;
  assign t_b1 = b ^ c1;
  assign b1   = {t_b1[19:0], t_b1[31:20]};
  assign qa   = a1 + b1;
  assign t_d2 = d1 ^ qa;
  assign qd   = {t_d2[23:0], t_d2[31:24]};
  assign qc   = c1 + qd;
  assign t_b2 = b1 ^ qc;
  assign qb   = {t_b2[24:0], t_b2[31:25]};

endmodule

// File: rtl/chacha_block_seq.sv
// Sequential ChaCha block engine with a narrow streaming bus.
// One quarter-round per clock through a single chacha_qr instance.
//   clk, rst_n : clock, synchronous active-low reset
//   data_in    : load beat (little-endian bytes, word 0 first)
//   wr         : load strobe, taken in IDLE only
//   start      : begin block, taken in IDLE when wr=0
//   rd         : consume current output beat, effective when out_valid=1
//   data_out   : current output beat, 0 when out_valid=0
//   ready      : IDLE
//   busy       : COPY/CALC/SUM/INC
//   out_valid  : keystream block available
//   done       : one-cycle pulse after the last beat is consumed
module chacha_block_seq
  import chacha_pkg::*;
#(
  parameter int ROUNDS   = 20,
  parameter int BUS_W    = 8,
  parameter int CTR_W    = 32,
  parameter int AUTO_INC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] data_in,
  input  logic             wr,
  input  logic             start,
  input  logic             rd,
  output logic [BUS_W-1:0] data_out,
  output logic             ready,
  output logic             busy,
  output logic             out_valid,
  output logic             done
);

  localparam int             BEATS     = beats_of(BUS_W);
  localparam int             PW        = $clog2(BEATS);
  localparam logic [PW-1:0]  LAST_BEAT = PW'(BEATS - 1);
  localparam logic [4:0]     LAST_RND  = 5'(ROUNDS - 1);

  if ((ROUNDS % 2) != 0 || ROUNDS < 2 || ROUNDS > 20) begin : g_bad_rounds
    $error("chacha_block_seq: ROUNDS must be even, 2..20");
  end
  if (BUS_W != 8 && BUS_W != 16 && BUS_W != 32) begin : g_bad_bus
    $error("chacha_block_seq: BUS_W must be 8, 16 or 32");
  end
  if (CTR_W != 32 && CTR_W != 64) begin : g_bad_ctr
    $error("chacha_block_seq: CTR_W must be 32 or 64");
  end

  state_e             st;
  logic [511:0]       in_st;     // host-loaded input state, word w at [w*32 +: 32]
  logic [15:0][31:0]  wk;        // working state, holds the keystream in OUT
  logic [511:0]       wk_flat;
  logic [PW-1:0]      wptr, rptr;
  logic [4:0]         rnd;
  logic [1:0]         qi;

  // Operand selection: round parity picks column vs diagonal table.
  logic [3:0][3:0]    idx;
  logic [31:0]        qa, qb, qc, qd;

  assign idx = rnd[0] ? DIAG_IDX[qi] : COL_IDX[qi];

  chacha_qr u_qr (
    .a  (wk[idx[0]]),
    .b  (wk[idx[1]]),
    .c  (wk[idx[2]]),
    .d  (wk[idx[3]]),
    .qa (qa),
    .qb (qb),
    .qc (qc),
    .qd (qd)
  );

  assign wk_flat  = wk;
  assign data_out = out_valid ? wk_flat[rptr*BUS_W +: BUS_W] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      ready     <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      rnd       <= '0;
      qi        <= '0;
      in_st     <= '0;
      wk        <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          // wr wins over a coincident start
          if (wr) begin
            in_st[wptr*BUS_W +: BUS_W] <= data_in;
            wptr                       <= wptr + 1'b1;
          end else if (start) begin
            wptr  <= '0;
            st    <= COPY;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        COPY: begin
          wk  <= in_st;
          rnd <= '0;
          qi  <= '0;
          st  <= CALC;
        end
        CALC: begin
          wk[idx[0]] <= qa;
          wk[idx[1]] <= qb;
          wk[idx[2]] <= qc;
          wk[idx[3]] <= qd;
          qi         <= qi + 2'd1;
          if (qi == 2'd3) begin
            if (rnd == LAST_RND) begin
              rnd <= '0;
              st  <= SUM;
            end else begin
              rnd <= rnd + 5'd1;
            end
          end
        end
        SUM: begin
          for (int i = 0; i < 16; i++) wk[i] <= wk[i] + in_st[i*32 +: 32];
          st        <= OUT;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (rd) begin
            if (rptr == LAST_BEAT) begin
              rptr      <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              if (AUTO_INC != 0) begin
                st   <= INC;
                busy <= 1'b1;
              end else begin
                st    <= IDLE;
                ready <= 1'b1;
              end
            end else begin
              rptr <= rptr + 1'b1;
            end
          end
        end
        INC: begin
          if (CTR_W == 64)
            {in_st[13*32 +: 32], in_st[12*32 +: 32]} <=
              {in_st[13*32 +: 32], in_st[12*32 +: 32]} + 64'd1;
          else
            in_st[12*32 +: 32] <= in_st[12*32 +: 32] + 32'd1;
          st    <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          st    <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_seq.sv
// Directed bench: byte-wide ChaCha20 engine (32-bit counter) and
// word-wide ChaCha8 engine (64-bit counter), plus the quarter-round.
module tb_chacha_block_seq;
  import chacha_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // byte-wide ChaCha20, 32-bit counter
  logic       rst8_n, wr8, start8, rd8, rdy8, busy8, ov8, done8;
  logic [7:0] din8, dout8;
  // word-wide ChaCha8, 64-bit counter
  logic        rst32_n, wr32, start32, rd32, rdy32, busy32, ov32, done32;
  logic [31:0] din32, dout32;
  // stand-alone quarter-round
  logic [31:0] qa_i, qb_i, qc_i, qd_i, qa_o, qb_o, qc_o, qd_o;

  chacha_block_seq #(.ROUNDS(20), .BUS_W(8), .CTR_W(32), .AUTO_INC(1)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .data_in(din8), .wr(wr8), .start(start8), .rd(rd8),
    .data_out(dout8), .ready(rdy8), .busy(busy8), .out_valid(ov8), .done(done8));

  chacha_block_seq #(.ROUNDS(8), .BUS_W(32), .CTR_W(64), .AUTO_INC(1)) u_dut32 (
    .clk(clk), .rst_n(rst32_n), .data_in(din32), .wr(wr32), .start(start32), .rd(rd32),
    .data_out(dout32), .ready(rdy32), .busy(busy32), .out_valid(ov32), .done(done32));

  chacha_qr u_qr (.a(qa_i), .b(qb_i), .c(qc_i), .d(qd_i),
                  .qa(qa_o), .qb(qb_o), .qc(qc_o), .qd(qd_o));

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qrf(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] model(input logic [511:0] s, input int rounds);
    logic [31:0]  x [16];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) x[i] = s[i*32 +: 32];
    for (int r = 0; r < rounds; r += 2) begin
      {x[0], x[4], x[8],  x[12]} = qrf(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qrf(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qrf(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qrf(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qrf(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qrf(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qrf(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qrf(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) o[i*32 +: 32] = x[i] + s[i*32 +: 32];
    return o;
  endfunction

  // RFC 8439 2.3.2 state: key 00..1f, nonce 09000000/4a000000/00000000
  function automatic logic [511:0] mk_state(input logic [31:0] w12, input logic [31:0] w13);
    logic [511:0] s;
    s[127:0] = SIGMA;
    for (int i = 0; i < 32; i++) s[128 + i*8 +: 8] = 8'(i);
    s[12*32 +: 32] = w12;
    s[13*32 +: 32] = w13;
    s[14*32 +: 32] = 32'h4a000000;
    s[15*32 +: 32] = 32'h0;
    return s;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic load8(input logic [511:0] s, input int first);
    for (int i = first; i < 64; i++) begin
      @(negedge clk); wr8 = 1'b1; din8 = s[i*8 +: 8];
    end
    @(negedge clk); wr8 = 1'b0;
  endtask

  task automatic load32(input logic [511:0] s);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); wr32 = 1'b1; din32 = s[i*32 +: 32];
    end
    @(negedge clk); wr32 = 1'b0;
  endtask

  task automatic start_8();
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
  endtask

  task automatic start_32();
    @(negedge clk); start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
  endtask

  task automatic wait_ov8(output int lat);
    lat = 0;
    while (!ov8 && lat < 300) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait_ov32(output int lat);
    lat = 0;
    while (!ov32 && lat < 300) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic read8(output logic [511:0] blk, output int done_at, output int done_cnt);
    blk = '0; done_at = -1; done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); blk[i*8 +: 8] = dout8; rd8 = 1'b1;
      @(posedge clk); #1; rd8 = 1'b0;
      if (done8) begin done_cnt++; done_at = i; end
    end
  endtask

  task automatic read32(output logic [511:0] blk, output int done_at, output int done_cnt);
    blk = '0; done_at = -1; done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); blk[i*32 +: 32] = dout32; rd32 = 1'b1;
      @(posedge clk); #1; rd32 = 1'b0;
      if (done32) begin done_cnt++; done_at = i; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst8_n = 1'b0; rst32_n = 1'b0;
    wr8 = 0; start8 = 0; rd8 = 0; din8 = 0;
    wr32 = 0; start32 = 0; rd32 = 0; din32 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdy8, busy8, ov8, done8} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags8 got %b exp 1000", {rdy8, busy8, ov8, done8});
    end
    checks++;
    if (dout8 !== 8'h00) begin errors++; $display("FAIL reset_dout8 got %h exp 00", dout8); end
    checks++;
    if ({rdy32, busy32, ov32, done32} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags32 got %b exp 1000", {rdy32, busy32, ov32, done32});
    end
    checks++;
    if (dout32 !== 32'h0) begin errors++; $display("FAIL reset_dout32 got %h exp 0", dout32); end
    @(negedge clk); rst8_n = 1'b1; rst32_n = 1'b1;
  endtask

  task automatic test_qr();
    qa_i = 32'h11111111; qb_i = 32'h01020304; qc_i = 32'h9b8d6f43; qd_i = 32'h01234567;
    #1;
    checks++; if (qa_o !== 32'hea2a92f4) begin errors++; $display("FAIL qr_a got %h exp ea2a92f4", qa_o); end
    checks++; if (qb_o !== 32'hcb1cf8ce) begin errors++; $display("FAIL qr_b got %h exp cb1cf8ce", qb_o); end
    checks++; if (qc_o !== 32'h4581472e) begin errors++; $display("FAIL qr_c got %h exp 4581472e", qc_o); end
    checks++; if (qd_o !== 32'h5881c4bb) begin errors++; $display("FAIL qr_d got %h exp 5881c4bb", qd_o); end
  endtask

  task automatic test_rfc_block();
    logic [511:0] blk, exp;
    int lat, da, dc;
    load8(mk_state(32'h1, 32'h09000000), 0);
    start_8();
    checks++;
    if ({rdy8, busy8} !== 2'b01) begin errors++; $display("FAIL rfc_busy got %b exp 01", {rdy8, busy8}); end
    wait_ov8(lat);
    checks++;
    if (lat != 82) begin errors++; $display("FAIL rfc_latency got %0d exp 82", lat); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout8 !== 8'h10) begin errors++; $display("FAIL rfc_hold_beat0 got %h exp 10", dout8); end
    read8(blk, da, dc);
    // bytes 0..15: 10 f1 e7 e4 d1 3b 59 15 50 0f dd 1f a3 20 71 c4
    checks++;
    if (blk[127:0] !== 128'hc47120a3_1fdd0f50_15593bd1_e4e7f110) begin
      errors++; $display("FAIL rfc_bytes0_15 got %h exp c47120a31fdd0f5015593bd1e4e7f110", blk[127:0]);
    end
    checks++;
    if (blk[511:504] !== 8'h4e) begin errors++; $display("FAIL rfc_byte63 got %h exp 4e", blk[511:504]); end
    exp = model(mk_state(32'h1, 32'h09000000), 20);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL rfc_block got %h exp %h", blk, exp); end
    checks++;
    if (dc != 1 || da != 63) begin errors++; $display("FAIL rfc_done got beat %0d count %0d exp beat 63 count 1", da, dc); end
    checks++;
    if ({rdy8, busy8, ov8} !== 3'b010) begin errors++; $display("FAIL rfc_inc_state got %b exp 010", {rdy8, busy8, ov8}); end
    @(posedge clk); #1;
    checks++;
    if ({rdy8, busy8} !== 2'b10) begin errors++; $display("FAIL rfc_idle_after got %b exp 10", {rdy8, busy8}); end
  endtask

  // Second block without reload, with start/wr/rd poked while computing.
  task automatic test_auto_inc();
    logic [511:0] blk, exp;
    int lat, da, dc;
    start_8();
    lat = 0;
    while (!ov8 && lat < 300) begin
      if (lat == 3 || lat == 40) begin start8 = 1; wr8 = 1; rd8 = 1; din8 = 8'hff; end
      else begin start8 = 0; wr8 = 0; rd8 = 0; end
      @(posedge clk); #1; lat++;
    end
    start8 = 0; wr8 = 0; rd8 = 0;
    checks++;
    if (lat != 82) begin errors++; $display("FAIL autoinc_latency got %0d exp 82", lat); end
    read8(blk, da, dc);
    exp = model(mk_state(32'h2, 32'h09000000), 20);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL autoinc_block got %h exp %h", blk, exp); end
    @(posedge clk); #1;
  endtask

  // wr+start coincidence on the first beat, then 32-bit counter wrap.
  task automatic test_ctr_wrap32();
    logic [511:0] s, blk, exp;
    int lat, da, dc;
    @(negedge clk); rst8_n = 1'b0;
    @(negedge clk); rst8_n = 1'b1;
    s = mk_state(32'hFFFFFFFF, 32'h09000000);
    @(negedge clk); wr8 = 1'b1; start8 = 1'b1; din8 = s[7:0];
    @(posedge clk); #1; wr8 = 1'b0; start8 = 1'b0;
    checks++;
    if ({rdy8, busy8} !== 2'b10) begin errors++; $display("FAIL wr_start_ready got %b exp 10", {rdy8, busy8}); end
    load8(s, 1);
    start_8();
    wait_ov8(lat);
    read8(blk, da, dc);
    exp = model(s, 20);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL wr_start_block got %h exp %h", blk, exp); end
    @(posedge clk); #1;
    start_8();
    wait_ov8(lat);
    read8(blk, da, dc);
    exp = model(mk_state(32'h0, 32'h09000000), 20);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL ctr32_wrap_block got %h exp %h", blk, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_bus32();
    logic [511:0] blk, exp;
    int lat, da, dc;
    load32(mk_state(32'h1, 32'h09000000));
    start_32();
    wait_ov32(lat);
    checks++;
    if (lat != 34) begin errors++; $display("FAIL bus32_latency got %0d exp 34", lat); end
    read32(blk, da, dc);
    exp = model(mk_state(32'h1, 32'h09000000), 8);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL bus32_block got %h exp %h", blk, exp); end
    checks++;
    if (dc != 1 || da != 15) begin errors++; $display("FAIL bus32_done got beat %0d count %0d exp beat 15 count 1", da, dc); end
    @(posedge clk); #1;
    start_32();
    wait_ov32(lat);
    read32(blk, da, dc);
    exp = model(mk_state(32'h2, 32'h09000000), 8);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL bus32_autoinc got %h exp %h", blk, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_ctr_wrap64();
    logic [511:0] blk, exp;
    int lat, da, dc;
    load32(mk_state(32'hFFFFFFFF, 32'h00000005));
    start_32();
    wait_ov32(lat);
    read32(blk, da, dc);
    exp = model(mk_state(32'hFFFFFFFF, 32'h00000005), 8);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL ctr64_first got %h exp %h", blk, exp); end
    @(posedge clk); #1;
    start_32();
    wait_ov32(lat);
    read32(blk, da, dc);
    exp = model(mk_state(32'h0, 32'h00000006), 8);
    checks++;
    if (blk !== exp) begin errors++; $display("FAIL ctr64_carry got %h exp %h", blk, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int rose;
    start_8();
    repeat (20) @(posedge clk);
    #1; rst8_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rdy8, busy8, ov8, done8} !== 4'b1000) begin
      errors++; $display("FAIL midreset_flags got %b exp 1000", {rdy8, busy8, ov8, done8});
    end
    checks++;
    if (dout8 !== 8'h00) begin errors++; $display("FAIL midreset_dout got %h exp 00", dout8); end
    rst8_n = 1'b1;
    rose = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ov8 || busy8) rose++;
    end
    checks++;
    if (rose != 0) begin errors++; $display("FAIL midreset_resume got %0d active cycles exp 0", rose); end
  endtask

  initial begin
    test_reset();
    test_qr();
    test_rfc_block();
    test_auto_inc();
    test_ctr_wrap32();
    test_bus32();
    test_ctr_wrap64();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
